// File: rtl/reflet_irq_scheduler_pkg.sv
// rtl/reflet_irq_scheduler_pkg.sv - shared field offsets and line FSM encoding for the irq scheduler
package reflet_irq_scheduler_pkg;

    localparam int N_LINES      = 4;
    localparam int CFG_EN_BIT   = 0;
    localparam int CFG_EDGE_BIT = 1;
    localparam int CFG_LINE_LSB = 2;

    typedef enum logic [1:0] {
        LINE_IDLE    = 2'd0,
        LINE_ASSERT  = 2'd1,
        LINE_SERVICE = 2'd2
    } line_state_e;

endpackage

// File: rtl/reflet_irq_scheduler_rr_arbiter.sv
// rtl/reflet_irq_scheduler_rr_arbiter.sv - round-robin pick of the lowest request at or above ptr, wrapping
module reflet_rr_arbiter #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    input  logic [3:0]       ptr,
    output logic [3:0]       gid,
    output logic             found
);

    logic [2*N_SRC-1:0] dbl;

    // Rotating a doubled copy puts source ptr at bit 0, so a plain lowest-bit scan implements the wrap.
    always_comb begin
        dbl   = {req, req} >> ptr;
        gid   = '0;
        found = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                if (int'(ptr) + i >= N_SRC) begin
                    gid = 4'(int'(ptr) + i - N_SRC);
                end else begin
                    gid = 4'(int'(ptr) + i);
                end
            end
        end
    end

endmodule

// File: rtl/reflet_irq_scheduler.sv
// rtl/reflet_irq_scheduler.sv - schedules N_SRC requests onto 4 ext_int lines with claim/complete
// Optional input synchronizer: define REFLET_IRQ_SYNC_EN.
module reflet_irq_scheduler
    import reflet_irq_scheduler_pkg::*;
#(
    parameter int wordsize = 16,
    parameter int N_SRC    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_SRC-1:0]    irq_src,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_addr,
    input  logic [wordsize-1:0] cfg_wdata,
    output logic [wordsize-1:0] cfg_rdata,
    input  logic                int_ack,
    input  logic [1:0]          int_ack_line,
    output logic [3:0]          ext_int
);

    logic [N_SRC-1:0] irq_s;

`ifdef REFLET_IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end
    assign irq_s = sync2_q;
`else
    assign irq_s = irq_src;
`endif

    logic [3:0]       cfg_q [N_SRC];
    logic [3:0]       cfg_d [N_SRC];
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] irq_prev_q;
    line_state_e      state_q [N_LINES];
    line_state_e      state_d [N_LINES];
    logic [3:0]       rr_q [N_LINES];
    logic [3:0]       rr_d [N_LINES];
    logic [3:0]       claim_id_q [N_LINES];
    logic [3:0]       claim_id_d [N_LINES];
    logic [N_LINES-1:0] claim_valid_q, claim_valid_d;

    logic [N_SRC-1:0] elig [N_LINES];
    logic [3:0]       gid_w [N_LINES];
    logic [N_LINES-1:0] found_w;
    logic [N_SRC-1:0] claimed;
    logic [N_LINES-1:0] complete;
    logic             unused_wdata;

    assign unused_wdata = ^cfg_wdata[wordsize-1:4];

    for (genvar l = 0; l < N_LINES; l++) begin : g_line
        reflet_rr_arbiter #(.N_SRC(N_SRC)) u_arb (
            .req   (elig[l]),
            .ptr   (rr_q[l]),
            .gid   (gid_w[l]),
            .found (found_w[l])
        );
    end

    always_comb begin
        claimed  = '0;
        complete = '0;
        for (int l = 0; l < N_LINES; l++) begin
            complete[l] = cfg_we && (cfg_addr == 4'(N_SRC + l)) && (state_q[l] == LINE_SERVICE);
            for (int s = 0; s < N_SRC; s++) begin
                if (claim_valid_q[l] && claim_id_q[l] == 4'(s)) claimed[s] = 1'b1;
            end
        end
        for (int l = 0; l < N_LINES; l++) begin
            elig[l] = '0;
            for (int s = 0; s < N_SRC; s++) begin
                elig[l][s] = pending_q[s] && cfg_q[s][CFG_EN_BIT] && !claimed[s]
                             && (cfg_q[s][CFG_LINE_LSB +: 2] == 2'(l));
            end
        end
    end

    // Edge sources: completion clears first so a coincident new edge wins; disabling overrides both.
    always_comb begin
        pending_d = pending_q;
        for (int s = 0; s < N_SRC; s++) begin
            cfg_d[s] = cfg_q[s];
            if (cfg_we && cfg_addr == 4'(s)) cfg_d[s] = cfg_wdata[3:0];
            if (cfg_q[s][CFG_EDGE_BIT]) begin
                for (int l = 0; l < N_LINES; l++) begin
                    if (complete[l] && claim_id_q[l] == 4'(s)) pending_d[s] = 1'b0;
                end
                if (irq_s[s] && !irq_prev_q[s]) pending_d[s] = 1'b1;
            end else begin
                pending_d[s] = irq_s[s];
            end
            if (!cfg_q[s][CFG_EN_BIT]) pending_d[s] = 1'b0;
        end
    end

    always_comb begin
        claim_valid_d = claim_valid_q;
        for (int l = 0; l < N_LINES; l++) begin
            state_d[l]    = state_q[l];
            rr_d[l]       = rr_q[l];
            claim_id_d[l] = claim_id_q[l];
            ext_int[l]    = (state_q[l] == LINE_ASSERT);
            case (state_q[l])
                LINE_IDLE: begin
                    if (found_w[l]) begin
                        state_d[l]       = LINE_ASSERT;
                        claim_id_d[l]    = gid_w[l];
                        claim_valid_d[l] = 1'b1;
                        rr_d[l]          = (gid_w[l] == 4'(N_SRC - 1)) ? 4'd0 : gid_w[l] + 4'd1;
                    end
                end
                LINE_ASSERT: begin
                    if (int_ack && int_ack_line == 2'(l)) state_d[l] = LINE_SERVICE;
                end
                LINE_SERVICE: begin
                    if (complete[l]) begin
                        state_d[l]       = LINE_IDLE;
                        claim_valid_d[l] = 1'b0;
                    end
                end
                default: state_d[l] = LINE_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_rdata = '0;
        for (int s = 0; s < N_SRC; s++) begin
            if (cfg_addr == 4'(s)) cfg_rdata[3:0] = cfg_q[s];
        end
        for (int l = 0; l < N_LINES; l++) begin
            if (cfg_addr == 4'(N_SRC + l)) begin
                cfg_rdata[wordsize-1] = claim_valid_q[l];
                cfg_rdata[3:0]        = claim_id_q[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q     <= '0;
            irq_prev_q    <= '0;
            claim_valid_q <= '0;
            for (int s = 0; s < N_SRC; s++) cfg_q[s] <= '0;
            for (int l = 0; l < N_LINES; l++) begin
                state_q[l]    <= LINE_IDLE;
                rr_q[l]       <= '0;
                claim_id_q[l] <= '0;
            end
        end else begin
            pending_q     <= pending_d;
            irq_prev_q    <= irq_s;
            claim_valid_q <= claim_valid_d;
            for (int s = 0; s < N_SRC; s++) cfg_q[s] <= cfg_d[s];
            for (int l = 0; l < N_LINES; l++) begin
                state_q[l]    <= state_d[l];
                rr_q[l]       <= rr_d[l];
                claim_id_q[l] <= claim_id_d[l];
            end
        end
    end

endmodule
